// File: rtl/bsg_tiehi_staged_release.sv
// Staged replacement for an all-ones tie-high bus: groups of output bits rise one group at a time, delay_p cycles apart.
// Optional macro BSG_TIEHI_STAGED_RAMPDOWN_EN makes clear_i lower the groups in reverse order instead of all at once.
module bsg_tiehi_staged_release #(
  parameter int width_p  = 64,
  parameter int groups_p = 8,
  parameter int delay_p  = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               start_v_i,
  output logic               start_ready_o,
  input  logic               clear_i,
  input  logic               abort_i,
  output logic [width_p-1:0] o_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int gw_lp    = width_p / groups_p;
  localparam int cnt_w_lp = (delay_p > 1) ? $clog2(delay_p) : 1;
  localparam int idx_w_lp = (groups_p > 1) ? $clog2(groups_p) : 1;

  localparam logic [cnt_w_lp-1:0] reload_lp = cnt_w_lp'(delay_p - 1);
  localparam logic [idx_w_lp-1:0] last_lp   = idx_w_lp'(groups_p - 1);

  typedef enum logic [1:0] {IDLE, RAMP, DONE, RAMPDN} state_e;

  state_e              state;
  logic [cnt_w_lp-1:0] cnt;
  logic [idx_w_lp-1:0] idx;

  function automatic logic [width_p-1:0] group_bits(input logic [idx_w_lp-1:0] g);
    logic [width_p-1:0] bits;
    bits = '0;
    for (int i = 0; i < width_p; i++) bits[i] = ((i / gw_lp) == int'(g));
    return bits;
  endfunction

  // Abort outranks every state transition, including a start arriving in the same cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      o_o           <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      start_ready_o <= 1'b1;
    end else if (abort_i) begin
      state         <= IDLE;
      cnt           <= '0;
      idx           <= '0;
      o_o           <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      start_ready_o <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start_v_i && start_ready_o) begin
            state         <= RAMP;
            cnt           <= reload_lp;
            idx           <= '0;
            busy_o        <= 1'b1;
            start_ready_o <= 1'b0;
          end
        end
        RAMP: begin
          if (cnt == '0) begin
            o_o <= o_o | group_bits(idx);
            if (idx == last_lp) begin
              state  <= DONE;
              cnt    <= '0;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              idx <= idx + idx_w_lp'(1);
              cnt <= reload_lp;
            end
          end else begin
            cnt <= cnt - cnt_w_lp'(1);
          end
        end
        DONE: begin
          if (clear_i) begin
`ifdef BSG_TIEHI_STAGED_RAMPDOWN_EN
            state  <= RAMPDN;
            cnt    <= reload_lp;
            idx    <= last_lp;
            busy_o <= 1'b1;
            done_o <= 1'b0;
`else
            state         <= IDLE;
            cnt           <= '0;
            idx           <= '0;
            o_o           <= '0;
            done_o        <= 1'b0;
            start_ready_o <= 1'b1;
`endif
          end
        end
        RAMPDN: begin
`ifdef BSG_TIEHI_STAGED_RAMPDOWN_EN
          // Falling order mirrors the ramp: highest group first, group 0 last.
          if (cnt == '0) begin
            o_o <= o_o & ~group_bits(idx);
            if (idx == '0) begin
              state         <= IDLE;
              busy_o        <= 1'b0;
              start_ready_o <= 1'b1;
            end else begin
              idx <= idx - idx_w_lp'(1);
              cnt <= reload_lp;
            end
          end else begin
            cnt <= cnt - cnt_w_lp'(1);
          end
`else
          state         <= IDLE;
          o_o           <= '0;
          busy_o        <= 1'b0;
          start_ready_o <= 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bsg_tiehi_staged_release.sv
// Directed table-driven bench for bsg_tiehi_staged_release (64 bits, 8 groups, 4-cycle spacing).
module tb_bsg_tiehi_staged_release;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_v;
  logic        start_ready;
  logic        clear;
  logic        abort;
  logic [63:0] o;
  logic        busy;
  logic        done;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bsg_tiehi_staged_release #(.width_p(64), .groups_p(8), .delay_p(4)) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .start_v_i    (start_v),
    .start_ready_o(start_ready),
    .clear_i      (clear),
    .abort_i      (abort),
    .o_o          (o),
    .busy_o       (busy),
    .done_o       (done)
  );

  typedef struct {
    logic        start;
    logic        clr;
    logic        abrt;
    logic [63:0] exp_o;
    logic        exp_ready;
    logic        exp_busy;
    logic        exp_done;
  } vec_t;

  vec_t vecs[$];

  // Expected output with the lowest k groups high.
  function automatic logic [63:0] m(input int k);
    if (k >= 8) return '1;
    return (64'd1 << (8 * k)) - 64'd1;
  endfunction

  function automatic void add(input logic s, input logic c, input logic a,
                              input logic [63:0] eo, input logic r, input logic b, input logic d);
    vec_t v;
    v.start = s; v.clr = c; v.abrt = a;
    v.exp_o = eo; v.exp_ready = r; v.exp_busy = b; v.exp_done = d;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic [63:0] eo, input logic r,
                         input logic b, input logic d);
    chk({tag, " o"}, o, eo);
    chk({tag, " ready"}, 64'(start_ready), 64'(r));
    chk({tag, " busy"}, 64'(busy), 64'(b));
    chk({tag, " done"}, 64'(done), 64'(d));
  endtask

  task automatic run_vecs(input string tag);
    foreach (vecs[i]) begin
      start_v = vecs[i].start;
      clear   = vecs[i].clr;
      abort   = vecs[i].abrt;
      @(posedge clk); #1;
      chk_all($sformatf("%s[%0d]", tag, i), vecs[i].exp_o, vecs[i].exp_ready,
              vecs[i].exp_busy, vecs[i].exp_done);
    end
    start_v = 1'b0; clear = 1'b0; abort = 1'b0;
    vecs.delete();
  endtask

  initial begin
    reset_n = 1'b0; start_v = 1'b0; clear = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    chk_all("reset", 64'd0, 1'b1, 1'b0, 1'b0);

    // Full ramp, with a stray clear during RAMP and starts during DONE that must be ignored.
    add(1, 0, 0, 64'd0, 0, 1, 0);
    for (int e = 1; e <= 32; e++)
      add(0, (e == 6), 0, m(e / 4), 0, (e < 32), (e == 32));
    add(1, 0, 0, '1, 0, 0, 1);
    add(1, 0, 0, '1, 0, 0, 1);
`ifdef BSG_TIEHI_STAGED_RAMPDOWN_EN
    add(0, 1, 0, '1, 0, 1, 0);
    for (int e = 1; e <= 32; e++)
      add(0, 0, 0, m(8 - e / 4), (e == 32), (e < 32), 0);
`else
    add(0, 1, 0, 64'd0, 1, 0, 0);
`endif
    add(0, 0, 0, 64'd0, 1, 0, 0);
    run_vecs("ramp");

    // Start and abort in the same cycle: the start is dropped.
    add(1, 0, 1, 64'd0, 1, 0, 0);
    add(0, 0, 0, 64'd0, 1, 0, 0);
    add(0, 0, 0, 64'd0, 1, 0, 0);
    run_vecs("start_abort");

    // Abort mid-ramp at edge 14, then a fresh start begins again at group 0.
    add(1, 0, 0, 64'd0, 0, 1, 0);
    for (int e = 1; e <= 13; e++) add(0, 0, 0, m(e / 4), 0, 1, 0);
    add(0, 0, 1, 64'd0, 1, 0, 0);
    add(1, 0, 0, 64'd0, 0, 1, 0);
    for (int e = 1; e <= 8; e++) add(0, 0, 0, m(e / 4), 0, 1, 0);
    add(0, 0, 1, 64'd0, 1, 0, 0);
    run_vecs("abort");

    // Asynchronous reset in the middle of RAMP, between clock edges.
    start_v = 1'b1;
    @(posedge clk); #1 start_v = 1'b0;
    repeat (9) @(posedge clk);
    #1 chk_all("pre_reset", m(2), 1'b0, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1 chk_all("async_reset", 64'd0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1 reset_n = 1'b1;
    chk_all("post_reset", 64'd0, 1'b1, 1'b0, 1'b0);
    start_v = 1'b1;
    @(posedge clk); #1 start_v = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk_all("restart_g0", m(1), 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
